// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency-measurement sequencer:
// FSM state encoding, range type and per-range decade/gate helpers.
package freq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARM     = 3'd1;
  localparam state_t ST_GATE    = 3'd2;
  localparam state_t ST_LATCH   = 3'd3;
  localparam state_t ST_PRESENT = 3'd4;

  typedef logic [1:0] range_t;

  // Range r selects a gate of 1 s / 100 ms / 10 ms / 1 ms and a matching multiplier.
  localparam int unsigned DECADE [4] = '{1, 10, 100, 1000};

  function automatic int unsigned gate_len(input int unsigned clk_hz, input range_t r);
    return clk_hz / DECADE[r];
  endfunction

endpackage

// File: rtl/freq_meas_ctrl_edge_counter.sv
// Edge counter: 2-FF synchronizer on sig_in, rising-edge detect and a
// saturating CNT_W-bit counter gated by en and cleared by clr.
module edge_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic             w_rise;

  // NOTE: registers use <= so every flop samples the pre-edge value; blocking here would collapse the sync chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (en && w_rise) begin
      if (&r_count) begin
        r_sat <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count = r_count;
  assign sat   = r_sat;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Frequency-measurement sequencer: arm/gate/latch/present FSM, gate timer,
// decade scaling and valid/ready hand-off. Auto-ranging under FREQ_AUTORANGE_EN.
module freq_meas_ctrl
  import freq_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          CNT_W  = 32,
  parameter int unsigned HI_THR = 50_000,
  parameter int unsigned LO_THR = 4_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  input  logic        start,
  input  logic        cont,
  input  logic        auto_en,
  input  logic [1:0]  range_sel,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] freq_hz,
  output logic [1:0]  range_used,
  output logic        over,
  output logic        busy
);

  localparam int GATE_W = $clog2(CLK_HZ + 1);
  localparam int P_W    = (CNT_W + 10 > 33) ? CNT_W + 10 : 33;
  localparam int unsigned GATE_LEN [4] = '{gate_len(CLK_HZ, 2'd0), gate_len(CLK_HZ, 2'd1),
                                           gate_len(CLK_HZ, 2'd2), gate_len(CLK_HZ, 2'd3)};

  state_t             r_state;
  range_t             r_range;
  logic [GATE_W-1:0]  r_gate_cnt;
  logic               r_valid;
  logic [31:0]        r_freq;
  range_t             r_range_used;
  logic               r_over;

  logic [CNT_W-1:0]   w_count;
  logic               w_sat;
  logic [P_W-1:0]     w_cnt_ext;
  logic [P_W-1:0]     w_prod;
  logic               w_prod_ovf;
  range_t             w_next_range;

  edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (r_state == ST_ARM),
    .en     (r_state == ST_GATE),
    .sig_in (sig_in),
    .count  (w_count),
    .sat    (w_sat)
  );

  assign w_cnt_ext = P_W'(w_count);

  // NOTE: assign a default before the case so no path leaves w_prod unassigned (no latch).
  always_comb begin
    w_prod = w_cnt_ext;
    case (r_range)
      2'd0:    w_prod = w_cnt_ext;
      2'd1:    w_prod = (w_cnt_ext << 3) + (w_cnt_ext << 1);
      2'd2:    w_prod = (w_cnt_ext << 6) + (w_cnt_ext << 5) + (w_cnt_ext << 2);
      default: w_prod = (w_cnt_ext << 9) + (w_cnt_ext << 8) + (w_cnt_ext << 7)
                      + (w_cnt_ext << 6) + (w_cnt_ext << 5) + (w_cnt_ext << 3);
    endcase
  end

  assign w_prod_ovf = |w_prod[P_W-1:32];

`ifdef FREQ_AUTORANGE_EN
  localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;

  logic             r_auto_vld;
  range_t           r_auto_r;
  range_t           w_auto_next;
  logic [CMP_W-1:0] w_cnt_cmp;

  assign w_cnt_cmp = CMP_W'(w_count);

  always_comb begin
    w_auto_next = r_range;
    if (w_cnt_cmp >= CMP_W'(HI_THR) && r_range != 2'd3) begin
      w_auto_next = r_range + 2'd1;
    end else if (w_cnt_cmp < CMP_W'(LO_THR) && r_range != 2'd0) begin
      w_auto_next = r_range - 2'd1;
    end
  end

  // The decision is only remembered while auto-ranging; manual runs leave history alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_auto_vld <= 1'b0;
      r_auto_r   <= 2'd0;
    end else if (r_state == ST_LATCH && auto_en) begin
      r_auto_vld <= 1'b1;
      r_auto_r   <= w_auto_next;
    end
  end

  assign w_next_range = (auto_en && r_auto_vld) ? r_auto_r : range_sel;
`else
  logic w_unused_auto;
  assign w_unused_auto = auto_en ^ (HI_THR > LO_THR);
  assign w_next_range  = range_sel;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_range      <= 2'd0;
      r_gate_cnt   <= '0;
      r_valid      <= 1'b0;
      r_freq       <= '0;
      r_range_used <= 2'd0;
      r_over       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ARM;
            r_range <= w_next_range;
          end
        end
        ST_ARM: begin
          r_gate_cnt <= GATE_W'(GATE_LEN[r_range] - 1);
          r_state    <= ST_GATE;
        end
        ST_GATE: begin
          if (r_gate_cnt == '0) begin
            r_state <= ST_LATCH;
          end else begin
            r_gate_cnt <= r_gate_cnt - 1'b1;
          end
        end
        ST_LATCH: begin
          r_freq       <= w_prod_ovf ? 32'hFFFF_FFFF : w_prod[31:0];
          r_over       <= w_sat | w_prod_ovf;
          r_range_used <= r_range;
          r_valid      <= 1'b1;
          r_state      <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (r_valid && ready) begin
            r_valid <= 1'b0;
            if (cont) begin
              r_state <= ST_ARM;
              r_range <= w_next_range;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign valid      = r_valid;
  assign freq_hz    = r_freq;
  assign range_used = r_range_used;
  assign over       = r_over;
  assign busy       = (r_state != ST_IDLE);

endmodule
